// File: rtl/uart_rx_configurable.sv
// UART receiver with configurable width, parity, stop bits and oversampling.
// Includes an rx synchroniser, tick divider, start-glitch rejection and error flags.
module uart_rx_configurable #(
  parameter int DATA_BITS   = 8,
  parameter int PARITY_MODE = 0,
  parameter int STOP_BITS   = 1,
  parameter int OVERSAMPLE  = 16,
  parameter int FREQUENCY   = 100000000,
  parameter int BAUDRATE    = 115200
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] data,
  output logic                 data_valid,
  output logic                 parity_error,
  output logic                 framing_error,
  output logic                 busy
);

  localparam int DIV_RAW = FREQUENCY / (BAUDRATE * OVERSAMPLE);
  localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
  localparam int DIV_W   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int TCNT_W  = $clog2(OVERSAMPLE) + 1;
  localparam int BCNT_W  = $clog2(DATA_BITS) + 1;

  localparam logic [DIV_W-1:0]  DIV_LAST    = DIV_W'(DIV - 1);
  localparam logic [TCNT_W-1:0] T_HALF      = TCNT_W'(OVERSAMPLE / 2 - 1);
  localparam logic [TCNT_W-1:0] T_FULL      = TCNT_W'(OVERSAMPLE - 1);
  localparam logic [BCNT_W-1:0] B_DATA_LAST = BCNT_W'(DATA_BITS - 1);
  localparam logic [BCNT_W-1:0] B_STOP_LAST = BCNT_W'(STOP_BITS - 1);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

  state_t               state_q, state_d;
  logic                 rx_meta_q, rx_s_q;
  logic [DIV_W-1:0]     div_q, div_d;
  logic [TCNT_W-1:0]    tcnt_q, tcnt_d;
  logic [BCNT_W-1:0]    bcnt_q, bcnt_d;
  logic [DATA_BITS-1:0] sr_q, sr_d;
  logic                 perr_q, perr_d;
  logic                 ferr_q, ferr_d;
  logic                 armed_q, armed_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 data_valid_q, data_valid_d;
  logic                 parity_error_q, parity_error_d;
  logic                 framing_error_q, framing_error_d;
  logic                 busy_q, busy_d;
  logic                 tick;

  always_comb begin
    state_d         = state_q;
    tcnt_d          = tcnt_q;
    bcnt_d          = bcnt_q;
    sr_d            = sr_q;
    perr_d          = perr_q;
    ferr_d          = ferr_q;
    armed_d         = armed_q;
    data_d          = data_q;
    data_valid_d    = 1'b0;
    parity_error_d  = parity_error_q;
    framing_error_d = framing_error_q;
    tick            = (div_q == DIV_LAST);
    div_d           = tick ? '0 : div_q + 1'b1;

    case (state_q)
      S_IDLE: begin
        // armed stays low after a break until the line has been seen high again
        armed_d = armed_q | rx_s_q;
        if (armed_q && !rx_s_q) begin
          state_d = S_START;
          tcnt_d  = '0;
          div_d   = '0;
        end
      end
      S_START: begin
        if (tick) begin
          if (tcnt_q == T_HALF) begin
            tcnt_d = '0;
            if (rx_s_q) begin
              state_d = S_IDLE;
            end else begin
              state_d = S_DATA;
              bcnt_d  = '0;
              perr_d  = 1'b0;
              ferr_d  = 1'b0;
            end
          end else begin
            tcnt_d = tcnt_q + 1'b1;
          end
        end
      end
      S_DATA: begin
        if (tick) begin
          if (tcnt_q == T_FULL) begin
            tcnt_d = '0;
            sr_d   = {rx_s_q, sr_q[DATA_BITS-1:1]};
            bcnt_d = bcnt_q + 1'b1;
            if (bcnt_q == B_DATA_LAST) begin
              bcnt_d  = '0;
              state_d = (PARITY_MODE != 0) ? S_PARITY : S_STOP;
            end
          end else begin
            tcnt_d = tcnt_q + 1'b1;
          end
        end
      end
      S_PARITY: begin
        if (tick) begin
          if (tcnt_q == T_FULL) begin
            tcnt_d  = '0;
            perr_d  = (PARITY_MODE == 2) ? ~(^sr_q ^ rx_s_q) : (^sr_q ^ rx_s_q);
            state_d = S_STOP;
          end else begin
            tcnt_d = tcnt_q + 1'b1;
          end
        end
      end
      S_STOP: begin
        if (tick) begin
          if (tcnt_q == T_FULL) begin
            tcnt_d = '0;
            bcnt_d = bcnt_q + 1'b1;
            ferr_d = ferr_q | ~rx_s_q;
            if (bcnt_q == B_STOP_LAST) begin
              bcnt_d          = '0;
              data_d          = sr_q;
              parity_error_d  = (PARITY_MODE != 0) & perr_q;
              framing_error_d = ferr_q | ~rx_s_q;
              data_valid_d    = 1'b1;
              // re-arm at mid stop bit only if the line is high
              armed_d         = rx_s_q;
              state_d         = S_IDLE;
            end
          end else begin
            tcnt_d = tcnt_q + 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_meta_q       <= 1'b1;
      rx_s_q          <= 1'b1;
      state_q         <= S_IDLE;
      div_q           <= '0;
      tcnt_q          <= '0;
      bcnt_q          <= '0;
      sr_q            <= '0;
      perr_q          <= 1'b0;
      ferr_q          <= 1'b0;
      armed_q         <= 1'b0;
      data_q          <= '0;
      data_valid_q    <= 1'b0;
      parity_error_q  <= 1'b0;
      framing_error_q <= 1'b0;
      busy_q          <= 1'b0;
    end else begin
      rx_meta_q       <= rx;
      rx_s_q          <= rx_meta_q;
      state_q         <= state_d;
      div_q           <= div_d;
      tcnt_q          <= tcnt_d;
      bcnt_q          <= bcnt_d;
      sr_q            <= sr_d;
      perr_q          <= perr_d;
      ferr_q          <= ferr_d;
      armed_q         <= armed_d;
      data_q          <= data_d;
      data_valid_q    <= data_valid_d;
      parity_error_q  <= parity_error_d;
      framing_error_q <= framing_error_d;
      busy_q          <= busy_d;
    end
  end

  assign data          = data_q;
  assign data_valid    = data_valid_q;
  assign parity_error  = parity_error_q;
  assign framing_error = framing_error_q;
  assign busy          = busy_q;

endmodule

// File: tb/tb_uart_rx_configurable.sv
// Bench for uart_rx_configurable: 8N1, 8E1 and 8N2 instances at 16 clk per bit,
// table-driven frames plus hand-written corner sequences, scoreboard on data_valid.
module tb_uart_rx_configurable;

  logic       clk = 1'b0;
  logic       reset;
  logic       rx_line [3];
  logic [7:0] data_o  [3];
  logic       dv      [3];
  logic       perr    [3];
  logic       ferr    [3];
  logic       busy    [3];

  always #5 clk = ~clk;

  uart_rx_configurable #(.DATA_BITS(8), .PARITY_MODE(0), .STOP_BITS(1), .OVERSAMPLE(16),
                         .FREQUENCY(1600000), .BAUDRATE(100000)) u_n1 (
    .clk(clk), .reset(reset), .rx(rx_line[0]), .data(data_o[0]), .data_valid(dv[0]),
    .parity_error(perr[0]), .framing_error(ferr[0]), .busy(busy[0]));

  uart_rx_configurable #(.DATA_BITS(8), .PARITY_MODE(1), .STOP_BITS(1), .OVERSAMPLE(16),
                         .FREQUENCY(1600000), .BAUDRATE(100000)) u_e1 (
    .clk(clk), .reset(reset), .rx(rx_line[1]), .data(data_o[1]), .data_valid(dv[1]),
    .parity_error(perr[1]), .framing_error(ferr[1]), .busy(busy[1]));

  uart_rx_configurable #(.DATA_BITS(8), .PARITY_MODE(0), .STOP_BITS(2), .OVERSAMPLE(16),
                         .FREQUENCY(1600000), .BAUDRATE(100000)) u_n2 (
    .clk(clk), .reset(reset), .rx(rx_line[2]), .data(data_o[2]), .data_valid(dv[2]),
    .parity_error(perr[2]), .framing_error(ferr[2]), .busy(busy[2]));

  typedef struct {
    int         dut;
    logic [7:0] d;
    logic       pe;
    logic       fe;
  } exp_t;

  typedef struct {
    int         dut;
    logic [7:0] b;
    bit         par_en;
    bit         par_bit;
    int         nstop;
    bit         stop_val;
    logic [7:0] e_data;
    logic       e_pe;
    logic       e_fe;
  } vec_t;

  exp_t exp_q [$];
  vec_t vecs  [10];
  int   errors = 0;
  int   checks = 0;
  int   cyc    = 0;
  int   dv_count [3];
  int   dv_t2 [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input int d, input logic v, input int n);
    rx_line[d] = v;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_frame(input int d, input logic [7:0] b, input bit par_en,
                            input bit par_bit, input int nstop, input bit stop_val);
    drive(d, 1'b0, 16);
    for (int i = 0; i < 8; i++) drive(d, b[i], 16);
    if (par_en) drive(d, par_bit, 16);
    for (int i = 0; i < nstop; i++) drive(d, stop_val, 16);
  endtask

  task automatic expect_frame(input int d, input logic [7:0] v, input logic pe, input logic fe);
    exp_t e;
    e.dut = d; e.d = v; e.pe = pe; e.fe = fe;
    exp_q.push_back(e);
  endtask

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      cyc++;
      for (int i = 0; i < 3; i++) begin
        if (dv[i] === 1'b1) begin
          dv_count[i]++;
          if (i == 2) dv_t2.push_back(cyc);
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_valid: dut%0d got data %0h expected no valid", i, data_o[i]);
          end else begin
            e = exp_q.pop_front();
            chk("sb_dut", i, e.dut);
            chk("sb_data", data_o[i], e.d);
            chk("sb_parity_error", perr[i], e.pe);
            chk("sb_framing_error", ferr[i], e.fe);
          end
        end
      end
    end
  endtask

  task automatic chk_cleared(input int i);
    chk("rst_data", data_o[i], 0);
    chk("rst_valid", dv[i], 0);
    chk("rst_parity_error", perr[i], 0);
    chk("rst_framing_error", ferr[i], 0);
    chk("rst_busy", busy[i], 0);
  endtask

  initial begin
    int c;
    vecs[0] = '{0, 8'hA5, 0, 0, 1, 1, 8'hA5, 1'b0, 1'b0};
    vecs[1] = '{0, 8'h00, 0, 0, 1, 1, 8'h00, 1'b0, 1'b0};
    vecs[2] = '{0, 8'hFF, 0, 0, 1, 1, 8'hFF, 1'b0, 1'b0};
    vecs[3] = '{1, 8'h03, 1, 1, 1, 1, 8'h03, 1'b1, 1'b0};
    vecs[4] = '{1, 8'h03, 1, 0, 1, 1, 8'h03, 1'b0, 1'b0};
    vecs[5] = '{1, 8'hA5, 1, 0, 1, 1, 8'hA5, 1'b0, 1'b0};
    vecs[6] = '{1, 8'hA5, 1, 1, 1, 1, 8'hA5, 1'b1, 1'b0};
    vecs[7] = '{1, 8'h80, 1, 1, 1, 1, 8'h80, 1'b0, 1'b0};
    vecs[8] = '{1, 8'hC3, 1, 0, 1, 0, 8'hC3, 1'b0, 1'b1};
    vecs[9] = '{1, 8'hC3, 1, 0, 1, 1, 8'hC3, 1'b0, 1'b0};

    for (int i = 0; i < 3; i++) begin
      rx_line[i]  = 1'b1;
      dv_count[i] = 0;
    end
    reset = 1'b0;
    fork
      monitor();
    join_none
    repeat (3) @(negedge clk);
    for (int i = 0; i < 3; i++) chk_cleared(i);
    reset = 1'b1;
    repeat (4) @(negedge clk);

    // table-driven frames
    for (int k = 0; k < 10; k++) begin
      expect_frame(vecs[k].dut, vecs[k].e_data, vecs[k].e_pe, vecs[k].e_fe);
      send_frame(vecs[k].dut, vecs[k].b, vecs[k].par_en, vecs[k].par_bit,
                 vecs[k].nstop, vecs[k].stop_val);
      drive(vecs[k].dut, 1'b1, 32);
      chk("busy_after_frame", busy[vecs[k].dut], 0);
    end

    // bad stop bit followed by a long break: no re-arm until the line goes high
    expect_frame(0, 8'h55, 1'b0, 1'b1);
    send_frame(0, 8'h55, 0, 0, 1, 0);
    repeat (4) @(negedge clk);
    c = dv_count[0];
    drive(0, 1'b0, 640);
    chk("break_no_valid", dv_count[0], c);
    chk("break_idle", busy[0], 0);
    drive(0, 1'b1, 32);
    expect_frame(0, 8'h81, 1'b0, 1'b0);
    send_frame(0, 8'h81, 0, 0, 1, 1);
    drive(0, 1'b1, 32);

    // start-bit glitch
    c = dv_count[0];
    drive(0, 1'b0, 4);
    chk("glitch_busy_high", busy[0], 1);
    drive(0, 1'b1, 10);
    chk("glitch_busy_low", busy[0], 0);
    drive(0, 1'b1, 30);
    chk("glitch_no_valid", dv_count[0], c);

    // back-to-back 8N2 frames with no idle gap
    expect_frame(2, 8'h00, 1'b0, 1'b0);
    expect_frame(2, 8'hFF, 1'b0, 1'b0);
    send_frame(2, 8'h00, 0, 0, 2, 1);
    send_frame(2, 8'hFF, 0, 0, 2, 1);
    drive(2, 1'b1, 32);
    chk("b2b_count", dv_t2.size(), 2);
    if (dv_t2.size() >= 2) chk("b2b_spacing", dv_t2[1] - dv_t2[0], 176);

    // reset during data bit 3
    drive(0, 1'b0, 16);
    drive(0, 1'b0, 48);
    drive(0, 1'b0, 8);
    chk("midframe_busy", busy[0], 1);
    #2;
    reset      = 1'b0;
    rx_line[0] = 1'b1;
    #1;
    chk_cleared(0);
    @(negedge clk);
    repeat (5) @(negedge clk);
    reset = 1'b1;
    repeat (5) @(negedge clk);
    c = dv_count[0];
    expect_frame(0, 8'h3C, 1'b0, 1'b0);
    send_frame(0, 8'h3C, 0, 0, 1, 1);
    drive(0, 1'b1, 32);
    chk("post_reset_one_valid", dv_count[0], c + 1);

    for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(negedge clk);
    chk("sb_drained", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
